lcd_text_buffer: RTL and testbench

//  Character frame buffer and refresh scheduler feeding the HD44780 4-bit driver.

---
 rtl/lcd_text_buffer.sv | 157 +++++++++++++++
 tb/tb_lcd_text_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: 4x16 character frame buffer with a refresh scheduler for
// the HD44780 4-bit driver. Bytes arrive on a valid/ready port and are either
// stored at the cursor or decoded as control codes (clear, line feed, CR).
// The driver reads the buffer through rd_addr/rd_data. trg asks it for a
// print pass when content changed, the driver is idle and the holdoff expired.
//
// Handshake: a byte transfers on every rising clk edge where wr_valid and
// wr_ready are both high. wr_ready depends only on the FSM state, never on
// wr_valid. The upstream side holds wr_data stable while wr_valid is high
// and wr_ready is low.
module lcd_text_buffer #(
    parameter int         LINE_WIDTH         = 16,
    parameter int         LINES              = 4,
    parameter int         MEM_BITS           = 6,
    parameter int         MIN_REFRESH_CYCLES = 1000,
    parameter logic [7:0] FILL_CHAR          = 8'h20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [7:0]          wr_data,
    input  logic [MEM_BITS-1:0] rd_addr,
    output logic [7:0]          rd_data,
    input  logic                lcd_busy,
    output logic                trg,
    output logic [MEM_BITS-1:0] cursor,
    output logic                dbg_state
);

    localparam int DEPTH     = LINE_WIDTH * LINES;
    localparam int COL_BITS  = $clog2(LINE_WIDTH);
    localparam int LINE_BITS = MEM_BITS - COL_BITS;
    localparam int HOLD_BITS = $clog2(MIN_REFRESH_CYCLES + 1);

    localparam logic [MEM_BITS-1:0]  LAST_ADDR = MEM_BITS'(DEPTH - 1);
    localparam logic [MEM_BITS-1:0]  ADDR_ONE  = MEM_BITS'(1);
    localparam logic [LINE_BITS-1:0] LINE_ONE  = LINE_BITS'(1);
    localparam logic [HOLD_BITS-1:0] HOLD_LOAD = HOLD_BITS'(MIN_REFRESH_CYCLES);
    localparam logic [HOLD_BITS-1:0] HOLD_ONE  = HOLD_BITS'(1);
    localparam logic [HOLD_BITS-1:0] HOLD_ZERO = '0;

    localparam logic [7:0] CODE_CLEAR = 8'h0C;
    localparam logic [7:0] CODE_LF    = 8'h0A;
    localparam logic [7:0] CODE_CR    = 8'h0D;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [7:0]           mem [DEPTH];
    logic [MEM_BITS-1:0]  clr_idx;
    logic                 dirty;
    logic [HOLD_BITS-1:0] holdoff;

    logic                 accept;
    logic                 is_ctrl;
    logic                 clear_done;
    logic                 fire;
    logic                 set_dirty;
    logic                 mem_we;
    logic [MEM_BITS-1:0]  mem_waddr;
    logic [7:0]           mem_wdata;

    assign accept     = wr_valid && wr_ready;
    assign is_ctrl    = (wr_data == CODE_CLEAR) || (wr_data == CODE_LF) || (wr_data == CODE_CR);
    assign clear_done = (state == ST_CLEAR) && (clr_idx == LAST_ADDR);
    // trg itself is in the term so a pulse is never stretched to two cycles.
    assign fire       = (state == ST_RUN) && dirty && !lcd_busy && (holdoff == HOLD_ZERO) && !trg;
    assign set_dirty  = clear_done || (accept && !is_ctrl);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_CLEAR;
        else      state <= state_next;
    end

    // FSM next state: the clear sweep ends after the last address; a clear code restarts it.
    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (clr_idx == LAST_ADDR) state_next = ST_RUN;
            ST_RUN:   if (accept && (wr_data == CODE_CLEAR)) state_next = ST_CLEAR;
            default:  state_next = ST_CLEAR;
        endcase
    end

    // FSM outputs: the port is only open while running.
    always_comb begin
        wr_ready  = (state == ST_RUN);
        dbg_state = state;
    end

    // Memory write mux: the clear sweep owns the port in CLEAR, accepted characters in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cursor;
        mem_wdata = wr_data;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx;
            mem_wdata = FILL_CHAR;
        end else if (accept && !is_ctrl) begin
            mem_we = 1'b1;
        end
    end

    // Character RAM, not reset: contents survive rst until the clear sweep refills them.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Registered read port; a write to the same address this cycle returns the old byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data <= 8'h00;
        else      rd_data <= mem[rd_addr];
    end

    // Cursor and clear index: sweep in CLEAR, decode accepted bytes in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cursor  <= '0;
            clr_idx <= '0;
        end else if (state == ST_CLEAR) begin
            clr_idx <= clr_idx + ADDR_ONE;
        end else if (accept) begin
            case (wr_data)
                CODE_CLEAR: begin
                    cursor  <= '0;
                    clr_idx <= '0;
                end
                CODE_LF: cursor <= {cursor[MEM_BITS-1:COL_BITS] + LINE_ONE, {COL_BITS{1'b0}}};
                CODE_CR: cursor <= {cursor[MEM_BITS-1:COL_BITS], {COL_BITS{1'b0}}};
                default: cursor <= cursor + ADDR_ONE;
            endcase
        end
    end

    // Refresh scheduler: one trg pulse per change, spaced by the holdoff; a new write wins over the clear of dirty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trg     <= 1'b0;
            dirty   <= 1'b0;
            holdoff <= '0;
        end else begin
            trg <= fire;
            if (set_dirty)  dirty <= 1'b1;
            else if (fire)  dirty <= 1'b0;
            if (fire)                        holdoff <= HOLD_LOAD;
            else if (holdoff != HOLD_ZERO)   holdoff <= holdoff - HOLD_ONE;
        end
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed bench for lcd_text_buffer: reset/clear sweep, writes and reads,
// cursor wrap, control codes, refresh scheduling against lcd_busy, and
// clear/reset restarts.
module tb_lcd_text_buffer;

    localparam int MIN_REFRESH = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = 8'h00;
    logic [5:0] rd_addr = 6'd0;
    logic [7:0] rd_data;
    logic       lcd_busy = 1'b0;
    logic       trg;
    logic [5:0] cursor;
    logic       dbg_state;

    int checks = 0;
    int errors = 0;

    int cycle = 0;
    int trg_count = 0;
    int last_trg_cycle = 0;

    lcd_text_buffer #(
        .LINE_WIDTH(16), .LINES(4), .MEM_BITS(6),
        .MIN_REFRESH_CYCLES(MIN_REFRESH), .FILL_CHAR(8'h20)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .lcd_busy(lcd_busy), .trg(trg), .cursor(cursor), .dbg_state(dbg_state)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // trg pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rst && trg) begin
            trg_count      <= trg_count + 1;
            last_trg_cycle <= cycle;
        end
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Drive one byte and hold it until accepted; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = b;
        n = 0;
        while (!wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: byte %h not accepted, wr_ready=%b required 1", b, wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic read_mem(input logic [5:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    // Count negedges with wr_ready low, starting at the current negedge.
    task automatic count_ready_low(output int n);
        n = 0;
        while (!wr_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Number of addresses whose contents differ from fill, except addr 0 which must be first.
    task automatic count_bad_fill(input logic [7:0] first, output int bad);
        logic [7:0] d;
        bad = 0;
        for (int a = 0; a < 64; a++) begin
            read_mem(6'(a), d);
            if (d !== ((a == 0) ? first : 8'h20)) bad++;
        end
    endtask

    task automatic test_reset();
        int n;
        int bad;
        int c0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
        checks++; if (trg !== 1'b0) begin errors++; $display("FAIL reset_trg: got %b want 0", trg); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
        checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b want 0 (CLEAR)", dbg_state); end
        c0 = trg_count;
        rst = 1'b1;
        count_ready_low(n);
        checks++; if (n != 64) begin errors++; $display("FAIL reset_clear_len: wr_ready low %0d cycles want 64", n); end
        repeat (150) @(negedge clk);
        #1;
        checks++; if (trg_count - c0 != 1) begin errors++; $display("FAIL reset_trg_count: got %0d pulses want 1", trg_count - c0); end
        count_bad_fill(8'h20, bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_fill: %0d addresses differ, want 0", bad); end
    endtask

    task automatic test_write_read();
        send_byte(8'h41);
        send_byte(8'h42);
        checks++; if (cursor !== 6'd2) begin errors++; $display("FAIL wr_cursor: got %0d want 2", cursor); end
        @(negedge clk);
        rd_addr = 6'd0;
        @(negedge clk);
        checks++; if (rd_data !== 8'h41) begin errors++; $display("FAIL rd_addr0: got %h want 41", rd_data); end
        rd_addr = 6'd1;
        #1;
        checks++; if (rd_data !== 8'h41) begin errors++; $display("FAIL rd_latency: got %h want 41 before edge", rd_data); end
        @(negedge clk);
        checks++; if (rd_data !== 8'h42) begin errors++; $display("FAIL rd_addr1: got %h want 42", rd_data); end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        send_byte(8'h0D);
        checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL wrap_cr: got %0d want 0", cursor); end
        for (int i = 0; i < 64; i++) send_byte(8'h21 + 8'(i));
        checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL wrap_cursor0: got %0d want 0", cursor); end
        send_byte(8'h5A);
        checks++; if (cursor !== 6'd1) begin errors++; $display("FAIL wrap_cursor1: got %0d want 1", cursor); end
        read_mem(6'd0, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL wrap_mem0: got %h want 5a", d); end
        read_mem(6'd1, d);
        checks++; if (d !== 8'h22) begin errors++; $display("FAIL wrap_mem1: got %h want 22", d); end
        read_mem(6'd63, d);
        checks++; if (d !== 8'h60) begin errors++; $display("FAIL wrap_mem63: got %h want 60", d); end
    endtask

    task automatic test_ctrl_codes();
        logic [7:0] d;
        send_byte(8'h0D);
        repeat (5) send_byte(8'h71);
        checks++; if (cursor !== 6'd5) begin errors++; $display("FAIL ctrl_pre5: got %0d want 5", cursor); end
        send_byte(8'h0A);
        checks++; if (cursor !== 6'd16) begin errors++; $display("FAIL ctrl_lf5: got %0d want 16", cursor); end
        read_mem(6'd16, d);
        checks++; if (d !== 8'h31) begin errors++; $display("FAIL ctrl_lf_nowrite: got %h want 31", d); end
        send_byte(8'h0A);
        send_byte(8'h0A);
        repeat (2) send_byte(8'h71);
        checks++; if (cursor !== 6'd50) begin errors++; $display("FAIL ctrl_pre50: got %0d want 50", cursor); end
        send_byte(8'h0A);
        checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL ctrl_lf_wrap: got %0d want 0", cursor); end
        send_byte(8'h0A);
        repeat (5) send_byte(8'h71);
        send_byte(8'h0D);
        checks++; if (cursor !== 6'd16) begin errors++; $display("FAIL ctrl_cr21: got %0d want 16", cursor); end
        read_mem(6'd21, d);
        checks++; if (d !== 8'h36) begin errors++; $display("FAIL ctrl_mem21: got %h want 36", d); end
        read_mem(6'd50, d);
        checks++; if (d !== 8'h53) begin errors++; $display("FAIL ctrl_mem50: got %h want 53", d); end
        read_mem(6'd16, d);
        checks++; if (d !== 8'h71) begin errors++; $display("FAIL ctrl_mem16: got %h want 71", d); end
        read_mem(6'd49, d);
        checks++; if (d !== 8'h71) begin errors++; $display("FAIL ctrl_mem49: got %h want 71", d); end
    endtask

    task automatic test_busy_refresh();
        int c0;
        int t1;
        int n;
        @(negedge clk);
        lcd_busy = 1'b1;
        @(negedge clk);
        #1;
        c0 = trg_count;
        repeat (1100) @(negedge clk);
        repeat (3) send_byte(8'h78);
        repeat (20) @(negedge clk);
        #1;
        checks++; if (trg_count != c0) begin errors++; $display("FAIL busy_no_trg: got %0d pulses want 0", trg_count - c0); end
        @(negedge clk);
        lcd_busy = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (trg_count != c0 + 1) begin errors++; $display("FAIL busy_drop_trg: got %0d pulses want 1", trg_count - c0); end
        t1 = last_trg_cycle;
        send_byte(8'h79);
        n = 0;
        while (trg_count < c0 + 2 && n < 1200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++; if (trg_count != c0 + 2) begin errors++; $display("FAIL refresh_second_trg: got %0d pulses want 2", trg_count - c0); end
        // holdoff is loaded on the trg edge and must reach zero before the next trg
        checks++;
        if (last_trg_cycle - t1 < MIN_REFRESH || last_trg_cycle - t1 > MIN_REFRESH + 1) begin
            errors++;
            $display("FAIL refresh_spacing: got %0d cycles want %0d..%0d", last_trg_cycle - t1, MIN_REFRESH, MIN_REFRESH + 1);
        end
    endtask

    task automatic test_clear_and_reset();
        int n;
        int bad;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = 8'h0C;
        n = 0;
        while (!wr_ready && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        wr_data = 8'h48;
        count_ready_low(n);
        checks++; if (n != 64) begin errors++; $display("FAIL clr_len: wr_ready low %0d cycles want 64", n); end
        @(negedge clk);
        wr_valid = 1'b0;
        checks++; if (cursor !== 6'd1) begin errors++; $display("FAIL clr_held_cursor: got %0d want 1", cursor); end
        count_bad_fill(8'h48, bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL clr_fill: %0d addresses differ, want 0", bad); end

        send_byte(8'h0C);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL midrst_cursor: got %0d want 0", cursor); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL midrst_rd_data: got %h want 00", rd_data); end
        checks++; if (wr_ready !== 1'b0 || dbg_state !== 1'b0) begin errors++; $display("FAIL midrst_state: got ready=%b state=%b want 0/0", wr_ready, dbg_state); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        count_ready_low(n);
        checks++; if (n != 64) begin errors++; $display("FAIL midrst_clear_len: wr_ready low %0d cycles want 64", n); end
        count_bad_fill(8'h20, bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_fill: %0d addresses differ, want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_ctrl_codes();
        test_busy_refresh();
        test_clear_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
